fifo_rr_scheduler: RTL and testbench

FIFO_RR_SCHEDULER -- requirements
Module: fifo_rr_scheduler

---
 rtl/fifo_rr_scheduler.sv | 122 ++++++++++++
 tb/tb_fifo_rr_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: grants NUM_CH input FIFOs round-robin and drains up to
// BURST words per grant into one registered valid/ready output stream.
module fifo_rr_scheduler #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32,
    parameter int BURST  = 4,
    localparam int GW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CW    = $clog2(BURST) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ch_empty,
    output logic [NUM_CH-1:0]       ch_rd_en,
    input  logic [NUM_CH*WIDTH-1:0] ch_r_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic [GW-1:0]           out_ch,
    output logic                    out_last,
    output logic                    short_done,
    output logic [CW-1:0]           short_cnt,
    output logic                    busy
);

    typedef enum logic {IDLE, READ} state_t;

    localparam logic [CW-1:0] BURST_C = CW'(BURST);
    localparam logic [CW-1:0] LAST_C  = CW'(BURST - 1);
    localparam logic [GW-1:0] LAST_CH = GW'(NUM_CH - 1);

    state_t                        state;
    logic [GW-1:0]                 g;
    logic [GW-1:0]                 rr_ptr;
    logic [GW-1:0]                 g_inc;
    logic [GW-1:0]                 hit_ch;
    logic [GW-1:0]                 idx;
    logic                          hit;
    logic [CW-1:0]                 cnt;
    logic                          accept;
    logic                          rd_fire;
    logic [NUM_CH-1:0][WIDTH-1:0]  ch_words;

    assign ch_words = ch_r_data;
    assign accept   = !out_valid || out_ready;
    // Reads are gated by rst so no FIFO pops during a reset cycle.
    assign rd_fire  = !rst && (state == READ) && accept && !ch_empty[g] && (cnt < BURST_C);
    assign busy     = (state == READ);
    assign g_inc    = (g == LAST_CH) ? '0 : g + 1'b1;

    // Scan from the farthest offset down so the closest non-empty channel to rr_ptr wins.
    always_comb begin
        hit    = 1'b0;
        hit_ch = '0;
        idx    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = GW'((int'(rr_ptr) + i) % NUM_CH);
            if (!ch_empty[idx]) begin
                hit    = 1'b1;
                hit_ch = idx;
            end
        end
    end

    always_comb begin
        ch_rd_en = '0;
        if (rd_fire) ch_rd_en[g] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            g          <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            short_done <= 1'b0;
            short_cnt  <= '0;
        end else begin
            short_done <= 1'b0;

            if (rd_fire) begin
                out_data  <= $signed(ch_words[g]);
                out_ch    <= g;
                out_valid <= 1'b1;
                out_last  <= (cnt == LAST_C);
                cnt       <= cnt + 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (hit) begin
                        g     <= hit_ch;
                        cnt   <= '0;
                        state <= READ;
                    end
                end
                READ: begin
                    if (rd_fire && (cnt == LAST_C)) begin
                        state  <= IDLE;
                        rr_ptr <= g_inc;
                    end else if (accept && ch_empty[g]) begin
                        // A channel that drained before its first word just releases the grant.
                        state  <= IDLE;
                        rr_ptr <= g_inc;
                        if (cnt != '0) begin
                            short_done <= 1'b1;
                            short_cnt  <= cnt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler: FIFO models per channel, an always-ready
// or stalled sink, and a log of accepted words checked against hand-derived sequences.
module tb_fifo_rr_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   ch_empty;
    logic [3:0]   ch_rd_en;
    logic [127:0] ch_r_data;
    logic         out_valid;
    logic         out_ready;
    logic signed [31:0] out_data;
    logic [1:0]   out_ch;
    logic         out_last;
    logic         short_done;
    logic [2:0]   short_cnt;
    logic         busy;

    fifo_rr_scheduler #(.NUM_CH(4), .WIDTH(32), .BURST(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_empty   (ch_empty),
        .ch_rd_en   (ch_rd_en),
        .ch_r_data  (ch_r_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_last   (out_last),
        .short_done (short_done),
        .short_cnt  (short_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [4][32];
    logic [4:0]  rdp [4] = '{default: 5'd0};
    logic [4:0]  wrp [4] = '{default: 5'd0};
    int          fcnt[4] = '{default: 0};
    logic [3:0]  pop_req = 4'b0;

    logic [31:0] a_data [64];
    logic [1:0]  a_ch   [64];
    logic        a_last [64];
    int          n_acc = 0;
    logic [2:0]  sd_cnt [8];
    int          n_sd = 0;
    int          idle_bad = 0;
    int          proto_bad = 0;
    logic        watch_idle = 1'b0;

    int checks = 0;
    int failures = 0;

    // FIFO model: data visible combinationally, pop just after the edge that read it.
    for (genvar gi = 0; gi < 4; gi++) begin : g_fifo
        assign ch_empty[gi] = (fcnt[gi] == 0);
        assign ch_r_data[gi*32 +: 32] = mem[gi][rdp[gi]];
        always @(posedge clk) begin
            #1;
            if (pop_req[gi]) begin
                rdp[gi]  = rdp[gi] + 5'd1;
                fcnt[gi] = fcnt[gi] - 1;
            end
        end
    end

    always @(negedge clk) begin
        pop_req = ch_rd_en;
        if (out_valid && out_ready && n_acc < 64) begin
            a_data[n_acc] = out_data;
            a_ch[n_acc]   = out_ch;
            a_last[n_acc] = out_last;
            n_acc++;
        end
        if (short_done && n_sd < 8) begin
            sd_cnt[n_sd] = short_cnt;
            n_sd++;
        end
        if (watch_idle && (ch_rd_en != 4'b0 || out_valid || busy)) idle_bad++;
        if ($countones(ch_rd_en) > 1) proto_bad++;
        if (out_valid && !out_ready && ch_rd_en != 4'b0) proto_bad++;
        if (short_done && out_last) proto_bad++;
    end

    function automatic logic [31:0] word(input logic [1:0] c, input int k);
        return 32'hA000_0000 + 32'(c) * 32'h100 + 32'(k);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [1:0] c, input int k);
        mem[c][wrp[c]] = word(c, k);
        wrp[c] = wrp[c] + 5'd1;
        fcnt[c] = fcnt[c] + 1;
    endtask

    task automatic clear_log();
        n_acc = 0;
        n_sd  = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (fcnt[0] == 0 && fcnt[1] == 0 && fcnt[2] == 0 && fcnt[3] == 0 &&
                !busy && !out_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 32'(done), 32'd1);
        tick();
        tick();
    endtask

    task automatic wait_valid(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic chk_word(input int idx, input logic [1:0] c, input int k, input logic last);
        chk($sformatf("w%0d_data", idx), a_data[idx], word(c, k));
        chk($sformatf("w%0d_ch", idx), 32'(a_ch[idx]), 32'(c));
        chk($sformatf("w%0d_last", idx), 32'(a_last[idx]), 32'(last));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 32; j++) mem[c][j] = 32'h0;
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();

        // Reset values while rst is held
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rden", 32'(ch_rd_en), 0);
        chk("rst_data", out_data, 0);
        chk("rst_ch", 32'(out_ch), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_sdone", 32'(short_done), 0);
        chk("rst_scnt", 32'(short_cnt), 0);

        // All FIFOs empty for 10 cycles: nothing moves
        rst = 1'b0;
        idle_bad = 0;
        watch_idle = 1'b1;
        repeat (10) tick();
        watch_idle = 1'b0;
        chk("idle_quiet", 32'(idle_bad), 0);

        // ch1 with 6 words: full burst of 4, then short burst of 2
        clear_log();
        for (int k = 0; k < 6; k++) push(2'd1, k);
        drain("ch1_drain");
        chk("ch1_nacc", 32'(n_acc), 6);
        for (int k = 0; k < 6; k++) chk_word(k, 2'd1, k, k == 3);
        chk("ch1_nsd", 32'(n_sd), 1);
        chk("ch1_sdcnt", 32'(sd_cnt[0]), 2);

        // Four FIFOs with 8 words each: grant order 0,1,2,3,0,1,2,3
        do_reset();
        clear_log();
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 8; k++) push(2'(c), k);
        drain("rr_drain");
        chk("rr_nacc", 32'(n_acc), 32);
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < 4; k++)
                chk_word(b * 4 + k, 2'(b % 4), (b / 4) * 4 + k, k == 3);
        chk("rr_nsd", 32'(n_sd), 0);

        // ch0 burst with sink stalled 5 cycles after the first word
        do_reset();
        clear_log();
        for (int k = 0; k < 4; k++) push(2'd0, k);
        wait_valid("stall_first");
        out_ready = 1'b0;
        repeat (5) begin
            #1;
            chk("stall_data", out_data, word(2'd0, 0));
            chk("stall_ch", 32'(out_ch), 0);
            chk("stall_vld", 32'(out_valid), 1);
            chk("stall_rden", 32'(ch_rd_en), 0);
            tick();
        end
        out_ready = 1'b1;
        drain("stall_drain");
        chk("stall_nacc", 32'(n_acc), 4);
        for (int k = 0; k < 4; k++) chk_word(k, 2'd0, k, k == 3);

        // Reset during word 2 of a ch2 burst, with rr_ptr left at 2 by a ch1 burst
        do_reset();
        clear_log();
        for (int k = 0; k < 4; k++) push(2'd1, k);
        drain("pre_drain");
        clear_log();
        for (int k = 0; k < 4; k++) push(2'd2, k);
        wait_valid("mid_first");
        tick();
        chk("mid_word1", out_data, word(2'd2, 1));
        rst = 1'b1;
        #1;
        chk("mid_rst_rden", 32'(ch_rd_en), 0);
        tick();
        chk("mid_valid", 32'(out_valid), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_data", out_data, 0);
        chk("mid_ch", 32'(out_ch), 0);
        chk("mid_last", 32'(out_last), 0);
        chk("mid_sdone", 32'(short_done), 0);
        chk("mid_scnt", 32'(short_cnt), 0);
        chk("mid_rden", 32'(ch_rd_en), 0);
        rst = 1'b0;
        chk("mid_ch2_left", 32'(fcnt[2]), 2);
        clear_log();
        for (int k = 4; k < 8; k++) push(2'd1, k);
        drain("post_drain");
        chk("post_nacc", 32'(n_acc), 6);
        for (int k = 0; k < 4; k++) chk_word(k, 2'd1, k + 4, k == 3);
        chk_word(4, 2'd2, 2, 1'b0);
        chk_word(5, 2'd2, 3, 1'b0);
        chk("post_nsd", 32'(n_sd), 1);
        chk("post_sdcnt", 32'(sd_cnt[0]), 2);

        // Only ch3 non-empty: grant in the IDLE cycle, read on the next
        do_reset();
        clear_log();
        for (int k = 0; k < 4; k++) push(2'd3, k);
        #1;
        chk("ch3_idle_rden", 32'(ch_rd_en), 0);
        chk("ch3_idle_busy", 32'(busy), 0);
        tick();
        chk("ch3_read_busy", 32'(busy), 1);
        chk("ch3_read_rden", 32'(ch_rd_en), 32'h8);
        drain("ch3_drain");
        chk("ch3_nacc", 32'(n_acc), 4);
        for (int k = 0; k < 4; k++) chk_word(k, 2'd3, k, k == 3);
        // rr_ptr wrapped to 0: ch0 must beat ch3
        clear_log();
        push(2'd0, 0);
        push(2'd3, 4);
        drain("wrap_drain");
        chk("wrap_nacc", 32'(n_acc), 2);
        chk("wrap_first", 32'(a_ch[0]), 0);
        chk("wrap_second", 32'(a_ch[1]), 3);
        chk("wrap_nsd", 32'(n_sd), 2);
        chk("wrap_sdcnt", 32'(sd_cnt[0]), 1);

        chk("protocol", 32'(proto_bad), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
